serial_pattern_source: RTL



---
 rtl/pattern_pkg.sv | 22 ++
 rtl/serial_pattern_source_if.sv | 32 +++
 rtl/serial_pattern_source.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pattern_pkg.sv
// Shared types and helpers for the serial pattern source: state encoding,
// default sizes and the pattern-length clamp.
package pattern_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned REP_W_DEF = 8;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT
  } state_e;

  // A zero or oversized length means "send the whole register".
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned width);
    return ((len == 0) || (len > width)) ? width : len;
  endfunction

endpackage

// File: rtl/serial_pattern_source_if.sv
// Load handshake plus serial output bundle for serial_pattern_source.
// master = pattern provider / observer, slave = the pattern source itself.
interface serial_pattern_source_if
  import pattern_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int REP_W = REP_W_DEF
);
  localparam int LEN_W = $clog2(WIDTH + 1);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [LEN_W-1:0] load_len;
  logic [REP_W-1:0] load_rep;
  logic             stop;
  logic             bit_out;
  logic             bit_valid;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_data, load_len, load_rep, stop,
    input  load_ready, bit_out, bit_valid, busy, done
  );

  modport slave (
    input  load_valid, load_data, load_len, load_rep, stop,
    output load_ready, bit_out, bit_valid, busy, done
  );

endinterface

// File: rtl/serial_pattern_source.sv
// Serialises a loaded bit pattern MSB-first, one bit per clock, optionally
// repeated a fixed number of times or continuously until stopped.
module serial_pattern_source
  import pattern_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  serial_pattern_source_if.slave  bus
);

  localparam int LEN_W = $clog2(WIDTH + 1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [REP_W-1:0] REP_ZERO = '0;
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic [LEN_W-1:0] hold_len_q, hold_len_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             done_q, done_d;

  logic [LEN_W-1:0] len_in;
  logic [WIDTH-1:0] aligned;
  logic [REP_W-1:0] rep_next;

  function automatic logic [WIDTH-1:0] align_msb(input logic [WIDTH-1:0] data,
                                                 input logic [LEN_W-1:0] len);
    return data << (WIDTH - int'(len));
  endfunction

  assign len_in = LEN_W'(clamp_len(32'(bus.load_len), WIDTH));

  // shreg holds the bits still to come after the one on bit_out; cnt counts
  // them, so cnt==0 means the displayed bit closes the current repetition.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    rep_d       = rep_q;
    hold_data_d = hold_data_q;
    hold_len_d  = hold_len_q;
    bit_out_d   = 1'b0;
    bit_valid_d = 1'b0;
    done_d      = 1'b0;
    aligned     = '0;
    rep_next    = rep_q;

    case (state_q)
      S_IDLE: begin
        if (bus.load_valid) begin
          aligned     = align_msb(bus.load_data, len_in);
          hold_data_d = bus.load_data;
          hold_len_d  = len_in;
          rep_d       = bus.load_rep;
          bit_out_d   = aligned[WIDTH-1];
          bit_valid_d = 1'b1;
          shreg_d     = aligned << 1;
          cnt_d       = len_in - LEN_ONE;
          done_d      = (len_in == LEN_ONE) && (bus.load_rep == REP_ONE);
          state_d     = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (bus.stop || done_q) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          // Repetition boundary: restart from the held pattern with no gap.
          rep_next    = (rep_q == REP_ZERO) ? REP_ZERO : rep_q - REP_ONE;
          rep_d       = rep_next;
          aligned     = align_msb(hold_data_q, hold_len_q);
          bit_out_d   = aligned[WIDTH-1];
          bit_valid_d = 1'b1;
          shreg_d     = aligned << 1;
          cnt_d       = hold_len_q - LEN_ONE;
          done_d      = (hold_len_q == LEN_ONE) && (rep_next == REP_ONE);
        end else begin
          bit_out_d   = shreg_q[WIDTH-1];
          bit_valid_d = 1'b1;
          shreg_d     = shreg_q << 1;
          cnt_d       = cnt_q - LEN_ONE;
          done_d      = (cnt_q == LEN_ONE) && (rep_q == REP_ONE);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      rep_q       <= '0;
      hold_data_q <= '0;
      hold_len_q  <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      rep_q       <= rep_d;
      hold_data_q <= hold_data_d;
      hold_len_q  <= hold_len_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      done_q      <= done_d;
    end
  end

  assign bus.load_ready = (state_q == S_IDLE);
  assign bus.busy       = (state_q == S_SHIFT);
  assign bus.bit_out    = bit_out_q;
  assign bus.bit_valid  = bit_valid_q;
  assign bus.done       = done_q;

endmodule
